// File: rtl/pixel_writer_arbiter.sv
// pixel_writer_arbiter: merges escape-count results from the iterator columns
// round-robin, converts each one to an RGB332 colour and SRAM address in a
// two-stage pipeline, writes it to the VGA pixel SRAM and tracks frame progress.
module pixel_writer_arbiter #(
  parameter int PARTITION      = 2,
  parameter int MAX_ITERATIONS = 100,
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int ADDR_W         = 19
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [PARTITION-1:0]     res_valid,
  output logic [PARTITION-1:0]     res_ready,
  input  logic [PARTITION*11-1:0]  res_count,
  input  logic [PARTITION*10-1:0]  res_x,
  input  logic [PARTITION*9-1:0]   res_y,
  input  logic                     mem_busy,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [7:0]               mem_data,
  output logic [ADDR_W-1:0]        pixels_written,
  output logic                     frame_done
);

  localparam int PTR_W = (PARTITION > 1) ? $clog2(PARTITION) : 1;
  localparam logic [PTR_W:0]    PART_CNT    = (PTR_W+1)'(PARTITION);
  localparam logic [PTR_W-1:0]  PTR_LAST    = PTR_W'(PARTITION - 1);
  localparam logic [ADDR_W-1:0] FRAME_COUNT = ADDR_W'(SCREEN_W * SCREEN_H);
  localparam logic [ADDR_W-1:0] FRAME_LAST  = ADDR_W'(SCREEN_W * SCREEN_H - 1);
  localparam logic [10:0] TH_IN_SET = 11'(MAX_ITERATIONS);
  localparam logic [10:0] TH_QUART  = 11'(MAX_ITERATIONS / 4);
  localparam logic [10:0] TH_SIXT   = 11'(MAX_ITERATIONS / 16);
  localparam logic [10:0] TH_LOW    = 11'd2;

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W:0]    cand;
  logic              grant_found;
  logic              stall;
  logic              accept;
  logic              write_done;

  logic [10:0]       sel_count;
  logic [9:0]        sel_x;
  logic [8:0]        sel_y;

  logic              s1_valid;
  logic [10:0]       s1_count;
  logic [9:0]        s1_x;
  logic [8:0]        s1_y;

  logic              s2_valid;
  logic              s2_in_range;
  logic [7:0]        colour_next;
  logic [ADDR_W-1:0] addr_next;
  logic              in_range_next;

  // The whole pipeline freezes only when a write is waiting on a busy SRAM;
  // otherwise stage 1 always drains into stage 2, so a new grant is safe.
  assign stall      = mem_busy & s2_valid;
  assign accept     = ~reset & ~stall & grant_found;
  assign mem_we     = s2_valid & s2_in_range;
  assign write_done = mem_we & ~mem_busy;

  assign sel_count = res_count[11*int'(grant_idx) +: 11];
  assign sel_x     = res_x[10*int'(grant_idx) +: 10];
  assign sel_y     = res_y[9*int'(grant_idx) +: 9];

  // Find the first valid column at or after the round-robin pointer, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < PARTITION; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand >= PART_CNT) cand = cand - PART_CNT;
      if (!grant_found && res_valid[cand[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Ready is the one-hot grant, only while a transfer can actually happen.
  always_comb begin
    res_ready = '0;
    if (accept) res_ready[grant_idx] = 1'b1;
  end

  // Pointer moves just past the column that was served.
  always_ff @(posedge clk) begin
    if (reset)
      rr_ptr <= '0;
    else if (accept)
      rr_ptr <= (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;
  end

  // Stage 1 captures the granted column's raw result.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_count <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_count <= sel_count;
        s1_x     <= sel_x;
        s1_y     <= sel_y;
      end
    end
  end

  // Colour bands for the stage-1 count, darkest band first.
  always_comb begin
    if (s1_count >= TH_IN_SET)
      colour_next = 8'h00;
    else if (s1_count >= TH_QUART)
      colour_next = 8'hFC;
    else if (s1_count >= TH_SIXT)
      colour_next = 8'hE0;
    else if (s1_count >= TH_LOW)
      colour_next = 8'h03;
    else
      colour_next = 8'h01;
  end

  assign addr_next     = ADDR_W'(32'(s1_y) * 32'(SCREEN_W) + 32'(s1_x));
  assign in_range_next = (32'(s1_x) < 32'(SCREEN_W)) && (32'(s1_y) < 32'(SCREEN_H));

  // Stage 2 holds the SRAM write; off-screen pixels travel through without a strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid    <= 1'b0;
      s2_in_range <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_in_range <= in_range_next;
        mem_addr    <= addr_next;
        mem_data    <= colour_next;
      end
    end
  end

  // Count completed writes; start wins over a write finishing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixels_written <= '0;
      frame_done     <= 1'b0;
    end else if (start) begin
      pixels_written <= '0;
      frame_done     <= 1'b0;
    end else if (write_done && pixels_written != FRAME_COUNT) begin
      pixels_written <= pixels_written + 1'b1;
      if (pixels_written == FRAME_LAST) frame_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_writer_arbiter.sv
// Scoreboard bench for pixel_writer_arbiter: the driver pushes the expected
// SRAM write for every accepted in-range result, a monitor pops and compares.
module tb_pixel_writer_arbiter;

  typedef struct packed {
    logic [10:0] count;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [7:0]  exp_data;
  } pix_t;

  typedef struct {
    logic [18:0] addr;
    logic [7:0]  data;
    int          cycle;
    bit          chk_lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, mem_busy;
  logic [1:0]  res_valid, res_ready;
  logic [21:0] res_count;
  logic [19:0] res_x;
  logic [17:0] res_y;
  logic        mem_we, frame_done;
  logic [18:0] mem_addr, pixels_written;
  logic [7:0]  mem_data;

  logic        s_start, s_busy, s_we, s_done;
  logic [1:0]  s_valid, s_ready;
  logic [21:0] s_count;
  logic [19:0] s_x;
  logic [17:0] s_y;
  logic [18:0] s_addr, s_pixels;
  logic [7:0]  s_data;

  int   checks = 0;
  int   failures = 0;
  int   cycle_cnt = 0;
  int   exp_pixels = 0;
  bit   lat_mode = 1'b0;
  exp_t sb[$];
  pix_t q0[$];
  pix_t q1[$];
  int   acc_cols[$];

  pixel_writer_arbiter dut (
    .clk(clk), .reset(reset), .start(start),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_count(res_count), .res_x(res_x), .res_y(res_y),
    .mem_busy(mem_busy), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .pixels_written(pixels_written), .frame_done(frame_done)
  );

  pixel_writer_arbiter #(.SCREEN_W(4), .SCREEN_H(2)) u_small (
    .clk(clk), .reset(reset), .start(s_start),
    .res_valid(s_valid), .res_ready(s_ready),
    .res_count(s_count), .res_x(s_x), .res_y(s_y),
    .mem_busy(s_busy), .mem_we(s_we), .mem_addr(s_addr), .mem_data(s_data),
    .pixels_written(s_pixels), .frame_done(s_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  function automatic pix_t mkPix(input int count, input int x, input int y, input logic [7:0] d);
    pix_t p;
    p.count    = 11'(count);
    p.x        = 10'(x);
    p.y        = 9'(y);
    p.exp_data = d;
    return p;
  endfunction

  // Scoreboard push for every handshake seen on the result interface.
  task automatic recordAccept(input pix_t p, input int col);
    exp_t e;
    acc_cols.push_back(col);
    if (p.x < 10'd640 && p.y < 9'd480) begin
      e.addr    = 19'(32'(p.y) * 640 + 32'(p.x));
      e.data    = p.exp_data;
      e.cycle   = cycle_cnt;
      e.chk_lat = lat_mode;
      sb.push_back(e);
      exp_pixels++;
    end
  endtask

  // Drives both column queues; mem_busy high for cycles [busy_start, busy_start+busy_len).
  task automatic applyStimulus(input int busy_start, input int busy_len, input int budget);
    pix_t cur0 = '0;
    pix_t cur1 = '0;
    bit have0 = 1'b0;
    bit have1 = 1'b0;
    int cyc = 0;
    logic [18:0] hold_addr = '0;
    logic [7:0]  hold_data = '0;
    logic        hold_we = 1'b0;
    while ((q0.size() > 0 || q1.size() > 0 || have0 || have1) && cyc < budget) begin
      if (!have0 && q0.size() > 0) begin cur0 = q0.pop_front(); have0 = 1'b1; end
      if (!have1 && q1.size() > 0) begin cur1 = q1.pop_front(); have1 = 1'b1; end
      res_valid = {have1, have0};
      res_count = {cur1.count, cur0.count};
      res_x     = {cur1.x, cur0.x};
      res_y     = {cur1.y, cur0.y};
      mem_busy  = (cyc >= busy_start) && (cyc < busy_start + busy_len);
      @(negedge clk);
      if (res_ready != 2'b00 && res_ready != 2'b01 && res_ready != 2'b10)
        checkOutput("ready_onehot", 32'(res_ready), 32'(0));
      if (mem_busy) begin
        checkOutput("ready_in_stall", 32'(res_ready), 32'(0));
        if (cyc == busy_start) begin
          hold_addr = mem_addr; hold_data = mem_data; hold_we = mem_we;
          checkOutput("stall_we_high", 32'(mem_we), 32'(1));
        end else begin
          checkOutput("stall_addr_hold", 32'(mem_addr), 32'(hold_addr));
          checkOutput("stall_data_hold", 32'(mem_data), 32'(hold_data));
          checkOutput("stall_we_hold", 32'(mem_we), 32'(hold_we));
        end
      end
      if (have0 && res_ready[0]) begin recordAccept(cur0, 0); have0 = 1'b0; end
      if (have1 && res_ready[1]) begin recordAccept(cur1, 1); have1 = 1'b0; end
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= budget) checkOutput("stim_timeout_cycles", 32'(cyc), 32'(budget - 1));
    res_valid = 2'b00;
    mem_busy  = 1'b0;
  endtask

  // Lets the pipeline empty, then checks nothing is pending and the pixel count.
  task automatic drain(input string tag);
    res_valid = 2'b00;
    mem_busy  = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin @(posedge clk); #1; end
    repeat (2) begin @(posedge clk); #1; end
    checkOutput({tag, "_sb_left"}, 32'(sb.size()), 32'(0));
    @(negedge clk);
    checkOutput({tag, "_pixels_written"}, 32'(pixels_written), 32'(exp_pixels));
    @(posedge clk); #1;
  endtask

  // Monitor: every completed SRAM write must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1 && mem_busy === 1'b0) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_write: got write addr=%0d data=0x%0h, expected no write", mem_addr, mem_data);
        end else begin
          e = sb.pop_front();
          checkOutput("wr_addr", 32'(mem_addr), 32'(e.addr));
          checkOutput("wr_data", 32'(mem_data), 32'(e.data));
          if (e.chk_lat) checkOutput("wr_latency", 32'(cycle_cnt - e.cycle), 32'(2));
        end
      end
    end
  end

  initial begin
    int alt_err, n0, wr, p;
    reset = 1'b1; start = 1'b0; mem_busy = 1'b0;
    res_valid = 2'b11; res_count = '0; res_x = '0; res_y = '0;
    s_start = 1'b0; s_busy = 1'b0; s_valid = 2'b00; s_count = '0; s_x = '0; s_y = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mem_we", 32'(mem_we), 32'(0));
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'(0));
    checkOutput("rst_mem_data", 32'(mem_data), 32'(0));
    checkOutput("rst_res_ready", 32'(res_ready), 32'(0));
    checkOutput("rst_pixels", 32'(pixels_written), 32'(0));
    checkOutput("rst_frame_done", 32'(frame_done), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0; res_valid = 2'b00;

    // Single result: addr 2*640+3 = 1283, in-set colour 00, two-cycle latency.
    lat_mode = 1'b1;
    q0.push_back(mkPix(100, 3, 2, 8'h00));
    applyStimulus(-1, 0, 20);
    drain("single");

    // Colour thresholds at 100/4=25 and 100/16=6.
    q0.push_back(mkPix(0, 10, 5, 8'h01));
    q0.push_back(mkPix(1, 11, 5, 8'h01));
    q0.push_back(mkPix(2, 12, 5, 8'h03));
    q0.push_back(mkPix(6, 13, 5, 8'hE0));
    q0.push_back(mkPix(24, 14, 5, 8'hE0));
    q0.push_back(mkPix(25, 15, 5, 8'hFC));
    q0.push_back(mkPix(99, 16, 5, 8'hFC));
    applyStimulus(-1, 0, 40);
    drain("colour");

    // Screen boundaries: two off-screen results, then the last pixel 307199.
    q0.push_back(mkPix(50, 640, 0, 8'hFC));
    q1.push_back(mkPix(50, 0, 480, 8'hFC));
    q0.push_back(mkPix(50, 639, 479, 8'hFC));
    applyStimulus(-1, 0, 40);
    drain("boundary");
    checkOutput("boundary_expected_count", 32'(exp_pixels), 32'(9));

    // Backpressure: busy for three cycles once stage 2 is full.
    lat_mode = 1'b0;
    for (int j = 0; j < 6; j++) begin
      q0.push_back(mkPix(3, 20 + j, 10, 8'h03));
      q1.push_back(mkPix(12, 30 + j, 10, 8'hE0));
    end
    applyStimulus(3, 3, 60);
    drain("backpressure");

    // Fairness from a fresh pointer: both columns always valid.
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    sb.delete(); acc_cols.delete(); exp_pixels = 0;
    lat_mode = 1'b1;
    for (int j = 0; j < 50; j++) begin
      q0.push_back(mkPix(100, 2 * j, 7, 8'h00));
      q1.push_back(mkPix(30, 2 * j + 1, 7, 8'hFC));
    end
    applyStimulus(-1, 0, 200);
    drain("fairness");
    alt_err = 0; n0 = 0;
    foreach (acc_cols[k]) begin
      if (acc_cols[k] != k % 2) alt_err++;
      if (acc_cols[k] == 0) n0++;
    end
    checkOutput("fair_total", 32'(acc_cols.size()), 32'(100));
    checkOutput("fair_alternation_errors", 32'(alt_err), 32'(0));
    checkOutput("fair_col0_accepts", 32'(n0), 32'(50));

    // mem_busy with stage 2 empty does not block; then reset mid-stream.
    res_valid = 2'b01; res_count = {11'd0, 11'd50}; res_x = {10'd0, 10'd5}; res_y = {9'd0, 9'd5};
    mem_busy = 1'b1;
    @(negedge clk);
    checkOutput("busy_empty_s2_ready", 32'(res_ready), 32'(1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("busy_full_ready", 32'(res_ready), 32'(0));
    checkOutput("busy_full_we", 32'(mem_we), 32'(1));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_mem_we", 32'(mem_we), 32'(0));
    checkOutput("midrst_mem_addr", 32'(mem_addr), 32'(0));
    checkOutput("midrst_mem_data", 32'(mem_data), 32'(0));
    checkOutput("midrst_res_ready", 32'(res_ready), 32'(0));
    checkOutput("midrst_pixels", 32'(pixels_written), 32'(0));
    reset = 1'b0; res_valid = 2'b00; mem_busy = 1'b0;
    sb.delete(); exp_pixels = 0;
    repeat (4) begin @(posedge clk); #1; end
    drain("flushed");

    // Frame completion on a 4x2 screen instance: 8 in-range pixels.
    wr = 0; p = 0;
    s_valid = 2'b01; s_count = '0;
    for (int c = 0; c < 40 && wr < 8; c++) begin
      s_x = {10'd0, 10'(p % 4)};
      s_y = {9'd0, 9'(p / 4)};
      @(negedge clk);
      if (s_ready[0]) p++;
      if (s_we) begin
        wr++;
        if (wr == 8) checkOutput("frame_done_at_last_write", 32'(s_done), 32'(0));
      end
      @(posedge clk); #1;
    end
    s_valid = 2'b00;
    checkOutput("frame_writes_seen", 32'(wr), 32'(8));
    @(negedge clk);
    checkOutput("frame_done_after", 32'(s_done), 32'(1));
    checkOutput("frame_pixels", 32'(s_pixels), 32'(8));
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end

    // A write after completion still reaches the SRAM; frame_done stays set.
    s_valid = 2'b01; s_x = {10'd0, 10'd1}; s_y = {9'd0, 9'd1};
    @(posedge clk); #1; s_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("post_frame_we", 32'(s_we), 32'(1));
    checkOutput("post_frame_addr", 32'(s_addr), 32'(5));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("post_frame_done_held", 32'(s_done), 32'(1));
    @(posedge clk); #1;

    // start coinciding with a completing write clears both and drops that write.
    s_valid = 2'b01; s_x = {10'd0, 10'd2}; s_y = '0;
    @(posedge clk); #1; s_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("start_cycle_we", 32'(s_we), 32'(1));
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    @(negedge clk);
    checkOutput("start_pixels_cleared", 32'(s_pixels), 32'(0));
    checkOutput("start_done_cleared", 32'(s_done), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
